// File: rtl/dac_spi_pkg.sv
// Shared types and constants for the DAC SPI driver: FSM states, frame layout and the slew helper.
package dac_spi_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  localparam int         FRAME_BITS    = 16;
  localparam int         DATA_PAD      = 4;
  localparam logic [7:0] CODE_MIDSCALE = 8'd128;

  // Move cur toward tgt by at most step, landing exactly on tgt when closer than step.
  function automatic logic [7:0] slew_toward(input logic [7:0] cur, input logic [7:0] tgt,
                                             input logic [7:0] step);
    logic [7:0] diff;
    if (tgt > cur) begin
      diff = tgt - cur;
      return (diff > step) ? cur + step : tgt;
    end else begin
      diff = cur - tgt;
      return (diff > step) ? cur - step : tgt;
    end
  endfunction

endpackage

// File: rtl/dac_spi_driver_if.sv
// Upstream code/force inputs, status outputs and the three SPI pins of the DAC driver.
interface dac_spi_driver_if;
  logic [7:0] code_in;
  logic       force_update;
  logic       dac_cs_n;
  logic       dac_sclk;
  logic       dac_din;
  logic       busy;
  logic       frame_done;
  logic [7:0] sent_code;

  modport master (output code_in, force_update,
                  input  dac_cs_n, dac_sclk, dac_din, busy, frame_done, sent_code);
  modport slave  (input  code_in, force_update,
                  output dac_cs_n, dac_sclk, dac_din, busy, frame_done, sent_code);
endinterface

// File: rtl/spi_shift_tx.sv
// spi_shift_tx: 16-bit MSB-first SPI shifter, CLK_DIV clk per SCLK half-period, shifts on the falling edge.
// Latency: word loaded on start, done asserted in the last high-phase cycle; start while active restarts.
module spi_shift_tx
  import dac_spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] word,
  output logic                  sclk,
  output logic                  din,
  output logic                  done
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(FRAME_BITS);

  logic                  active;
  logic [PW-1:0]         phase;
  logic [BW-1:0]         bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  phase_end;

  assign phase_end = (phase == PW'(CLK_DIV - 1));
  assign done      = active && phase_end && sclk && (bit_cnt == BW'(FRAME_BITS - 1));
  assign din       = shreg[FRAME_BITS-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active  <= 1'b0;
      phase   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sclk    <= 1'b0;
    end else if (start) begin
      active  <= 1'b1;
      phase   <= '0;
      bit_cnt <= '0;
      shreg   <= word;
      sclk    <= 1'b0;
    end else if (active) begin
      if (phase_end) begin
        phase <= '0;
        if (!sclk) begin
          sclk <= 1'b1;
        end else begin
          // Falling edge: next bit appears while SCLK is low; zeros shift in so din rests low.
          sclk    <= 1'b0;
          shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BW'(FRAME_BITS - 1)) active <= 1'b0;
        end
      end else begin
        phase <= phase + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dac_spi_driver.sv
// dac_spi_driver: sends {CMD_WORD, code, 0000} to an SPI DAC on code change, force_update or refresh; DAC_SLEW_LIMIT_EN enables slew.
// Latency: IDLE->LOAD->32*CLK_DIV clk SHIFT->CS_GAP; no backpressure, code_in is only resampled in IDLE.
module dac_spi_driver
  import dac_spi_pkg::*;
#(
  parameter int         CLK_DIV        = 2,
  parameter logic [3:0] CMD_WORD       = 4'h3,
  parameter int         CS_GAP         = 4,
  parameter int         REFRESH_CYCLES = 50_000,
  parameter int         SLEW_STEP      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  dac_spi_driver_if.slave  bus
);

  localparam int TW = (REFRESH_CYCLES > 0) ? $clog2(REFRESH_CYCLES + 1) : 1;
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [TW-1:0] REFRESH_MAX = TW'(REFRESH_CYCLES);

  state_t                state, state_d;
  logic                  cs_n_q;
  logic                  frame_done_q;
  logic [7:0]            sent_code_q;
  logic [7:0]            tx_code;
  logic [7:0]            tx_next;
  logic                  pend_force;
  logic [TW-1:0]         refresh_cnt;
  logic                  refresh_due;
  logic [GW-1:0]         gap_cnt;
  logic                  start;
  logic                  shift_done;
  logic [FRAME_BITS-1:0] word;

`ifdef DAC_SLEW_LIMIT_EN
  assign tx_next = slew_toward(sent_code_q, bus.code_in, 8'(SLEW_STEP));
`else
  logic [7:0] unused_step;
  assign unused_step = 8'(SLEW_STEP);
  assign tx_next     = bus.code_in;
`endif

  assign word        = {CMD_WORD, tx_next, {DATA_PAD{1'b0}}};
  assign refresh_due = (REFRESH_CYCLES != 0) && (refresh_cnt == REFRESH_MAX);

  spi_shift_tx #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .word    (word),
    .sclk    (bus.dac_sclk),
    .din     (bus.dac_din),
    .done    (shift_done)
  );

  always_comb begin
    state_d = state;
    start   = 1'b0;
    case (state)
      IDLE:  if (pend_force || (bus.code_in != sent_code_q) || refresh_due) state_d = LOAD;
      LOAD:  begin
        start   = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: if (shift_done) state_d = GAP;
      GAP:   if (gap_cnt == GW'(CS_GAP - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cs_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
      sent_code_q  <= CODE_MIDSCALE;
      tx_code      <= CODE_MIDSCALE;
      pend_force   <= 1'b1;
      refresh_cnt  <= '0;
      gap_cnt      <= '0;
    end else begin
      state        <= state_d;
      cs_n_q       <= (state_d != SHIFT);
      frame_done_q <= (state == SHIFT) && shift_done;
      if ((state == SHIFT) && shift_done) sent_code_q <= tx_code;
      if (state == LOAD) tx_code <= tx_next;
      // A pulse landing in LOAD must survive the clear so it yields its own frame.
      if (bus.force_update)    pend_force <= 1'b1;
      else if (state == LOAD)  pend_force <= 1'b0;
      if (frame_done_q)                                       refresh_cnt <= '0;
      else if ((state == IDLE) && (refresh_cnt != REFRESH_MAX)) refresh_cnt <= refresh_cnt + 1'b1;
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
    end
  end

  assign bus.dac_cs_n   = cs_n_q;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = frame_done_q;
  assign bus.sent_code  = sent_code_q;

endmodule

// File: tb/tb_dac_spi_driver.sv
// Directed bench for dac_spi_driver: a pin monitor rebuilds each SPI frame, tasks compare against hand-computed words.
module tb_dac_spi_driver;

  localparam int REFRESH = 200;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  dac_spi_driver_if bus ();

  dac_spi_driver #(
    .CLK_DIV(2), .CMD_WORD(4'h3), .CS_GAP(4), .REFRESH_CYCLES(REFRESH), .SLEW_STEP(16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #10 clk = ~clk;

  logic [15:0] mon_bits = '0;
  int          mon_nbits = 0;
  int          mon_low = 0;
  logic        prev_sclk = 1'b0;
  logic        prev_cs = 1'b1;
  logic [15:0] q_word[$];
  int          q_nbits[$];
  int          q_low[$];
  logic        q_fd[$];

  always @(negedge clk) begin
    if (bus.dac_cs_n && !prev_cs) begin
      q_word.push_back(mon_bits);
      q_nbits.push_back(mon_nbits);
      q_low.push_back(mon_low);
      q_fd.push_back(bus.frame_done);
      mon_bits = '0;
      mon_nbits = 0;
      mon_low = 0;
    end
    if (!bus.dac_cs_n) mon_low++;
    if (bus.dac_sclk && !prev_sclk) begin
      mon_bits = {mon_bits[14:0], bus.dac_din};
      mon_nbits++;
    end
    prev_sclk = bus.dac_sclk;
    prev_cs = bus.dac_cs_n;
  end

  task automatic wait_frame(input int max_cyc, output bit ok);
    int n0;
    n0 = q_word.size();
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      #1;
      if (q_word.size() > n0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_cs_low(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!bus.dac_cs_n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_force();
    @(negedge clk);
    bus.force_update = 1'b1;
    @(negedge clk);
    bus.force_update = 1'b0;
  endtask

  task automatic test_reset(input logic [7:0] code);
    reset_n = 1'b0;
    bus.code_in = code;
    bus.force_update = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp += 6;
    if (bus.dac_cs_n !== 1'b1)    begin n_fail++; $display("FAIL rst_cs_n: got %b want 1", bus.dac_cs_n); end
    if (bus.dac_sclk !== 1'b0)    begin n_fail++; $display("FAIL rst_sclk: got %b want 0", bus.dac_sclk); end
    if (bus.dac_din !== 1'b0)     begin n_fail++; $display("FAIL rst_din: got %b want 0", bus.dac_din); end
    if (bus.busy !== 1'b0)        begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    if (bus.frame_done !== 1'b0)  begin n_fail++; $display("FAIL rst_frame_done: got %b want 0", bus.frame_done); end
    if (bus.sent_code !== 8'd128) begin n_fail++; $display("FAIL rst_sent_code: got %0d want 128", bus.sent_code); end
  endtask

  task automatic test_first_frame();
    bit ok;
    int n0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_frame(200, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL first_frame_timeout: got none want 1 frame"); end
    else begin
      n_cmp += 5;
      if (q_word[$] !== 16'h3A20) begin n_fail++; $display("FAIL first_word: got %h want 3a20", q_word[$]); end
      if (q_nbits[$] !== 16)      begin n_fail++; $display("FAIL first_nbits: got %0d want 16", q_nbits[$]); end
      if (q_low[$] !== 64)        begin n_fail++; $display("FAIL first_cs_low: got %0d want 64", q_low[$]); end
      if (q_fd[$] !== 1'b1)       begin n_fail++; $display("FAIL first_frame_done: got %b want 1", q_fd[$]); end
      if (bus.sent_code !== 8'd162) begin n_fail++; $display("FAIL first_sent_code: got %0d want 162", bus.sent_code); end
    end
    n0 = q_word.size();
    repeat (100) @(negedge clk);
    #1;
    n_cmp++;
    if (q_word.size() !== n0) begin n_fail++; $display("FAIL first_no_repeat: got %0d frames want %0d", q_word.size(), n0); end
  endtask

  task automatic test_refresh();
    bit ok;
    int idle;
    wait_frame(REFRESH + 50, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL refresh_timeout1: got none want frame"); end
    idle = 0;
    for (int i = 0; i < 10 && bus.busy; i++) @(negedge clk);
    while (!bus.busy && idle < 1000) begin
      idle++;
      @(negedge clk);
    end
    n_cmp++;
    if (idle !== REFRESH + 1) begin n_fail++; $display("FAIL refresh_idle_cycles: got %0d want %0d", idle, REFRESH + 1); end
    wait_frame(100, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL refresh_timeout2: got none want frame"); end
    else begin
      n_cmp++;
      if (q_word[$] !== 16'h3A20) begin n_fail++; $display("FAIL refresh_word: got %h want 3a20", q_word[$]); end
    end
  endtask

  task automatic test_code_change();
    bit ok;
    int idle;
    int load;
    pulse_force();
    wait_cs_low(50, ok);
    repeat (5) @(negedge clk);
    bus.code_in = 8'd201;
    repeat (10) @(negedge clk);
    bus.code_in = 8'd204;
    wait_frame(100, ok);
    n_cmp++;
    if (!ok || q_word[$] !== 16'h3A20) begin n_fail++; $display("FAIL inflight_word: got %h want 3a20", q_word[$]); end
    idle = 0;
    load = 0;
    for (int i = 0; i < 10 && bus.busy; i++) @(negedge clk);
    while (!bus.busy && idle < 50) begin idle++; @(negedge clk); end
    while (bus.busy && bus.dac_cs_n && load < 50) begin load++; @(negedge clk); end
    n_cmp += 2;
    if (idle !== 1) begin n_fail++; $display("FAIL change_idle_cycles: got %0d want 1", idle); end
    if (load !== 1) begin n_fail++; $display("FAIL change_load_cycles: got %0d want 1", load); end
    wait_frame(100, ok);
    n_cmp += 2;
    if (!ok || q_word[$] !== 16'h3CC0) begin n_fail++; $display("FAIL latest_word: got %h want 3cc0", q_word[$]); end
    if (bus.sent_code !== 8'd204) begin n_fail++; $display("FAIL latest_sent_code: got %0d want 204", bus.sent_code); end
  endtask

  task automatic test_force(input int pulses_in_frame);
    bit ok;
    int n0;
    n0 = q_word.size();
    pulse_force();
    wait_cs_low(50, ok);
    for (int p = 0; p < pulses_in_frame; p++) begin
      repeat (6) @(negedge clk);
      pulse_force();
    end
    wait_frame(150, ok);
    wait_frame(150, ok);
    repeat (100) @(negedge clk);
    #1;
    n_cmp++;
    if (q_word.size() !== n0 + 2) begin
      n_fail++;
      $display("FAIL force_frames_%0d: got %0d want %0d", pulses_in_frame, q_word.size() - n0, 2);
    end else begin
      n_cmp++;
      if (q_word[n0] !== 16'h3CC0 || q_word[n0+1] !== 16'h3CC0) begin
        n_fail++;
        $display("FAIL force_words_%0d: got %h %h want 3cc0 3cc0", pulses_in_frame, q_word[n0], q_word[n0+1]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    pulse_force();
    wait_cs_low(50, ok);
    repeat (29) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp += 4;
    if (bus.dac_cs_n !== 1'b1)    begin n_fail++; $display("FAIL midrst_cs_n: got %b want 1", bus.dac_cs_n); end
    if (bus.dac_sclk !== 1'b0)    begin n_fail++; $display("FAIL midrst_sclk: got %b want 0", bus.dac_sclk); end
    if (bus.sent_code !== 8'd128) begin n_fail++; $display("FAIL midrst_sent_code: got %0d want 128", bus.sent_code); end
    if (bus.busy !== 1'b0)        begin n_fail++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    bus.code_in = 8'd90;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (q_nbits[$] !== 7) begin n_fail++; $display("FAIL midrst_partial_bits: got %0d want 7", q_nbits[$]); end
    reset_n = 1'b1;
    wait_frame(200, ok);
    n_cmp += 3;
    if (!ok || q_word[$] !== 16'h35A0) begin n_fail++; $display("FAIL midrst_word: got %h want 35a0", q_word[$]); end
    if (q_nbits[$] !== 16) begin n_fail++; $display("FAIL midrst_nbits: got %0d want 16", q_nbits[$]); end
    if (q_low[$] !== 64)   begin n_fail++; $display("FAIL midrst_cs_low: got %0d want 64", q_low[$]); end
  endtask

`ifdef DAC_SLEW_LIMIT_EN
  task automatic test_slew();
    bit ok;
    int n0;
    logic [15:0] exp_w[5];
    exp_w = '{16'h3900, 16'h3A00, 16'h3B00, 16'h3C00, 16'h3C90};
    reset_n = 1'b0;
    bus.code_in = 8'd201;
    repeat (3) @(negedge clk);
    #1;
    n0 = q_word.size();
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_frame(200, ok);
      n_cmp++;
      if (!ok || q_word[$] !== exp_w[k]) begin n_fail++; $display("FAIL slew_word_%0d: got %h want %h", k, q_word[$], exp_w[k]); end
    end
    repeat (100) @(negedge clk);
    #1;
    n_cmp += 2;
    if (q_word.size() !== n0 + 5) begin n_fail++; $display("FAIL slew_frame_count: got %0d want 5", q_word.size() - n0); end
    if (bus.sent_code !== 8'd201) begin n_fail++; $display("FAIL slew_sent_code: got %0d want 201", bus.sent_code); end
  endtask
`endif

  initial begin
    bus.code_in = 8'd162;
    bus.force_update = 1'b0;
`ifdef DAC_SLEW_LIMIT_EN
    test_reset(8'd201);
    test_slew();
`else
    test_reset(8'd162);
    test_first_frame();
    test_refresh();
    test_code_change();
    test_force(1);
    test_force(2);
    test_reset_mid_frame();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
